tile_reset_sequencer: RTL

- Sits directly downstream of the TileLink tile reset controller, in the same clock sink domain.
- Consumes the controller's per-domain reset-request levels and applies them safely to each clock group (cbus, mbus, fbus, pbus, sbus_1, sbus_0, implicit).
- Assert order: reset first, then clock gate. Release order: clock ungate first, then reset.
- Sequences one domain at a time in fixed priority order so domains never transition simultaneously.

---
 rtl/tile_reset_pkg.sv | 20 ++
 rtl/reset_hold_counter.sv | 37 +++
 rtl/tile_reset_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tile_reset_pkg.sv
// rtl/tile_reset_pkg.sv - shared types and constants for the tile reset sequencer
package tile_reset_pkg;

    localparam int N_DOMAINS_DEF = 7;

    localparam int CBUS     = 0;
    localparam int MBUS     = 1;
    localparam int FBUS     = 2;
    localparam int PBUS     = 3;
    localparam int SBUS1    = 4;
    localparam int SBUS0    = 5;
    localparam int IMPLICIT = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/reset_hold_counter.sv
// rtl/reset_hold_counter.sv - loadable down-counter timing reset hold and clock settle windows
module reset_hold_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // load wins over decrement; decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tile_reset_sequencer.sv
// rtl/tile_reset_sequencer.sv - applies per-domain reset requests one domain at a time with safe clock gating order
module tile_reset_sequencer
    import tile_reset_pkg::*;
#(
    parameter int N_DOMAINS     = N_DOMAINS_DEF,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_DOMAINS-1:0] req_reset,
    output logic [N_DOMAINS-1:0] domain_reset,
    output logic [N_DOMAINS-1:0] domain_clk_en,
    output logic                 busy,
    output logic [2:0]           active_idx,
    output logic                 seq_done
);

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_e           state_q, state_d;
    logic [N_DOMAINS-1:0] applied_q, applied_d;
    logic [N_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic [N_DOMAINS-1:0] clk_en_q, clk_en_d;
    logic                 busy_q, busy_d;
    logic [2:0]           idx_q, idx_d;
    logic                 done_q, done_d;

    logic [N_DOMAINS-1:0] diff;
    logic [2:0]           sel;
    logic                 cnt_load;
    logic [CNT_W-1:0]     cnt_load_val;
    logic                 cnt_dec;
    logic                 cnt_zero;

    reset_hold_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // lowest mismatching domain gets serviced first
    always_comb begin
        diff = req_reset ^ applied_q;
        sel  = '0;
        for (int k = N_DOMAINS - 1; k >= 0; k--) begin
            if (diff[k]) begin
                sel = 3'(k);
            end
        end
    end

    // sequencing FSM: reset before gate on assert, ungate before release
    always_comb begin
        state_d      = state_q;
        applied_d    = applied_q;
        dom_rst_d    = dom_rst_q;
        clk_en_d     = clk_en_q;
        busy_d       = busy_q;
        idx_d        = idx_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (diff != '0) begin
                    idx_d    = sel;
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                    if (req_reset[sel]) begin
                        dom_rst_d[sel] = 1'b1;
                        cnt_load_val   = HOLD_LOAD;
                        state_d        = HOLD;
                    end else begin
                        clk_en_d[sel]  = 1'b1;
                        cnt_load_val   = SETTLE_LOAD;
                        state_d        = SETTLE;
                    end
                end
            end
            HOLD: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    clk_en_d[idx_q]  = 1'b0;
                    applied_d[idx_q] = 1'b1;
                    done_d           = 1'b1;
                    busy_d           = 1'b0;
                    idx_d            = '0;
                    state_d          = IDLE;
                end
            end
            SETTLE: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    dom_rst_d[idx_q] = 1'b0;
                    applied_d[idx_q] = 1'b0;
                    done_d           = 1'b1;
                    busy_d           = 1'b0;
                    idx_d            = '0;
                    state_d          = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    // state and output registers; reset puts every domain in reset with clocks running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            applied_q <= '1;
            dom_rst_q <= '1;
            clk_en_q  <= '1;
            busy_q    <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            applied_q <= applied_d;
            dom_rst_q <= dom_rst_d;
            clk_en_q  <= clk_en_d;
            busy_q    <= busy_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
        end
    end

    assign domain_reset  = dom_rst_q;
    assign domain_clk_en = clk_en_q;
    assign busy          = busy_q;
    assign active_idx    = idx_q;
    assign seq_done      = done_q;

endmodule
